// File: rtl/add_arbiter_if.sv
// Bundle of request, response and shared-adder signals for add_arbiter.
// slave is the arbiter's view; master is the requester/adder side.
interface add_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 32
);
   localparam int IDW = $clog2(N_REQ);

   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ*WIDTH-1:0] req_a;
   logic [N_REQ*WIDTH-1:0] req_b;
   logic [N_REQ-1:0]       rsp_valid;
   logic [WIDTH-1:0]       rsp_sum;
   logic [N_REQ-1:0]       rsp_ready;
   logic [WIDTH-1:0]       add_a;
   logic [WIDTH-1:0]       add_b;
   logic [WIDTH-1:0]       add_sum;
   logic                   busy;
   logic [IDW-1:0]         grant_id;

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready, add_sum,
      output req_ready, rsp_valid, rsp_sum, add_a, add_b, busy, grant_id
   );

   modport master (
      output req_valid, req_a, req_b, rsp_ready, add_sum,
      input  req_ready, rsp_valid, rsp_sum, add_a, add_b, busy, grant_id
   );
endinterface

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one registered-operand adder between N_REQ requesters.
// Define ADD_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module add_arbiter #(
   parameter int N_REQ   = 4,
   parameter int WIDTH   = 32,
   parameter int ADD_LAT = 3
) (
   input logic          clk,
   input logic          rst_n,
   add_arbiter_if.slave bus
);
   localparam int IDW  = $clog2(N_REQ);
   localparam int CNTW = $clog2(ADD_LAT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   grant_id;
   logic [IDW-1:0]   sel_id;
   logic [IDW-1:0]   scan_id;
   logic             sel_found;
   logic [CNTW-1:0]  cnt;
   logic [WIDTH-1:0] add_a, add_b, rsp_sum;
   logic [N_REQ-1:0] req_ready, rsp_valid;
   logic             req_hs, rsp_hs, cnt_done;

   function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int offset);
      int sum;
      sum = int'(base) + offset;
      if (sum >= N_REQ) sum = sum - N_REQ;
      return IDW'(sum);
   endfunction

   // Scanning downward from the farthest slot lets the nearest valid requester
   // at or above ptr overwrite the rest, giving a first-match without a found chain.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      sel_id    = '0;
      sel_found = 1'b0;
      scan_id   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         scan_id = wrap_add(ptr, k);
         if (bus.req_valid[scan_id]) begin
            sel_id    = scan_id;
            sel_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      rsp_valid = '0;
      req_hs    = 1'b0;
      rsp_hs    = 1'b0;
      cnt_done  = 1'b0;
      unique case (state)
         IDLE: begin
            if (rst_n && sel_found) begin
               req_ready[sel_id] = 1'b1;
               req_hs            = 1'b1;
               state_nxt         = EXEC;
            end
         end
         EXEC: begin
            if (cnt == CNTW'(1)) begin
               cnt_done  = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            rsp_valid[grant_id] = 1'b1;
            if (bus.rsp_ready[grant_id]) begin
               rsp_hs    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         add_a    <= '0;
         add_b    <= '0;
         rsp_sum  <= '0;
         grant_id <= '0;
      end else begin
         state <= state_nxt;
         if (req_hs) begin
            add_a    <= bus.req_a[int'(sel_id)*WIDTH +: WIDTH];
            add_b    <= bus.req_b[int'(sel_id)*WIDTH +: WIDTH];
            grant_id <= sel_id;
            cnt      <= CNTW'(ADD_LAT);
         end else if (state == EXEC) begin
            cnt <= cnt - CNTW'(1);
         end
         if (cnt_done) rsp_sum <= bus.add_sum;
      end
   end

`ifdef ADD_ARB_FIXED_PRIO_EN
   // Fixed priority: the scan always starts at requester 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr <= '0;
      else        ptr <= '0;
   end
`else
   // The requester after the one just served gets first look next time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (rsp_hs) begin
         if (grant_id == IDW'(N_REQ - 1)) ptr <= '0;
         else                             ptr <= grant_id + IDW'(1);
      end
   end
`endif

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_sum   = rsp_sum;
   assign bus.add_a     = add_a;
   assign bus.add_b     = add_b;
   assign bus.busy      = (state != IDLE);
   assign bus.grant_id  = grant_id;

   a_req_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
   a_rsp_valid_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rsp_valid));
   a_grant_in_range:   assert property (@(posedge clk) disable iff (!rst_n) int'(grant_id) < N_REQ);
   a_no_req_when_busy: assert property (@(posedge clk) disable iff (!rst_n) (state != IDLE) |-> (req_ready == '0));
endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter with a behavioural adder on add_a/add_b.
// Build with +define+ADD_ARB_FIXED_PRIO_EN to check the fixed-priority variant.
module tb_add_arbiter;
   localparam int N_REQ   = 4;
   localparam int WIDTH   = 32;
   localparam int ADD_LAT = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   add_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

   add_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ADD_LAT(ADD_LAT)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   assign bus.add_sum = bus.add_a + bus.add_b;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      bus.req_a[id*WIDTH +: WIDTH] = a;
      bus.req_b[id*WIDTH +: WIDTH] = b;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int left;
      left = budget;
      while (bus.busy === 1'b1 && left > 0) begin
         tick();
         left--;
      end
      total++;
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL %s: busy still %b after %0d cycles, required 0", name, bus.busy, budget);
      end
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      bus.req_valid = '1;
      bus.rsp_ready = '0;
      bus.req_a     = '1;
      bus.req_b     = '1;
      repeat (2) tick();
      total++;
      if (bus.req_ready !== 4'b0000) begin
         bad++;
         $display("FAIL reset_req_ready: got %b, required 0000", bus.req_ready);
      end
      total++;
      if ({bus.rsp_valid, bus.busy, bus.grant_id} !== 7'b0) begin
         bad++;
         $display("FAIL reset_ctrl: rsp_valid=%b busy=%b grant_id=%0d, required all 0",
                  bus.rsp_valid, bus.busy, bus.grant_id);
      end
      total++;
      if ({bus.rsp_sum, bus.add_a, bus.add_b} !== 96'b0) begin
         bad++;
         $display("FAIL reset_data: rsp_sum=%h add_a=%h add_b=%h, required 0",
                  bus.rsp_sum, bus.add_a, bus.add_b);
      end
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      rst_n         = 1'b1;
      tick();
   endtask

   task automatic test_single();
      int busy_cnt;
      busy_cnt = 0;
      set_ops(2, 32'h0000_0005, 32'h0000_0007);
      bus.rsp_ready = 4'b0100;
      bus.req_valid = 4'b0100;
      #1;
      total++;
      if (bus.req_ready !== 4'b0100) begin
         bad++;
         $display("FAIL single_req_ready: got %b, required 0100", bus.req_ready);
      end
      tick();
      bus.req_valid = '0;
      total++;
      if (bus.add_a !== 32'h5 || bus.add_b !== 32'h7 || bus.grant_id !== 2'd2) begin
         bad++;
         $display("FAIL single_operands: add_a=%h add_b=%h grant_id=%0d, required 5 7 2",
                  bus.add_a, bus.add_b, bus.grant_id);
      end
      for (int c = 1; c <= 6; c++) begin
         if (bus.busy === 1'b1) busy_cnt++;
         total++;
         if (c == ADD_LAT + 1) begin
            if (bus.rsp_valid !== 4'b0100 || bus.rsp_sum !== 32'h0000_000C) begin
               bad++;
               $display("FAIL single_rsp cycle %0d: rsp_valid=%b rsp_sum=%h, required 0100 0000000c",
                        c, bus.rsp_valid, bus.rsp_sum);
            end
         end else if (bus.rsp_valid !== 4'b0000) begin
            bad++;
            $display("FAIL single_rsp_idle cycle %0d: rsp_valid=%b, required 0000", c, bus.rsp_valid);
         end
         tick();
      end
      total++;
      if (busy_cnt != ADD_LAT + 1) begin
         bad++;
         $display("FAIL single_busy_len: busy for %0d cycles, required %0d", busy_cnt, ADD_LAT + 1);
      end
   endtask

   task automatic do_op(input string name, input int id, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] expected);
      set_ops(id, a, b);
      bus.rsp_ready = '1;
      bus.req_valid = N_REQ'(1) << id;
      #1;
      total++;
      if (bus.req_ready !== (N_REQ'(1) << id)) begin
         bad++;
         $display("FAIL %s_req_ready: got %b, required one-hot bit %0d", name, bus.req_ready, id);
      end
      tick();
      bus.req_valid = '0;
      repeat (ADD_LAT) tick();
      total++;
      if (bus.rsp_valid !== (N_REQ'(1) << id) || bus.rsp_sum !== expected) begin
         bad++;
         $display("FAIL %s_rsp: rsp_valid=%b rsp_sum=%h, required bit %0d sum %h",
                  name, bus.rsp_valid, bus.rsp_sum, id, expected);
      end
      tick();
   endtask

   task automatic test_wrap();
      do_op("wrap_ones", 1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
      do_op("wrap_msb", 3, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
      do_op("plain_add", 0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789);
      do_op("wrap_carry", 3, 32'hFFFF_FFF0, 32'h0000_0025, 32'h0000_0015);
   endtask

   task automatic test_round_robin();
      int hs_cyc[5];
      int hs_id[5];
      int exp_id[5];
      logic [WIDTH-1:0] exp_sum[N_REQ];
      int n;
`ifdef ADD_ARB_FIXED_PRIO_EN
      exp_id = '{0, 0, 0, 0, 0};
`else
      exp_id = '{0, 1, 2, 3, 0};
`endif
      n = 0;
      for (int i = 0; i < N_REQ; i++) begin
         set_ops(i, 32'h100 * (i + 1), WIDTH'(i));
         exp_sum[i] = 32'h100 * (i + 1) + WIDTH'(i);
      end
      bus.rsp_ready = '1;
      bus.req_valid = '1;
      #1;
      for (int c = 0; c < 60 && n < 5; c++) begin
         if (bus.req_ready !== '0) begin
            hs_cyc[n] = c;
            hs_id[n]  = -1;
            for (int k = 0; k < N_REQ; k++) if (bus.req_ready[k] === 1'b1) hs_id[n] = k;
            n++;
         end else if (bus.rsp_valid !== '0 && n > 0) begin
            total++;
            if (bus.rsp_valid !== (N_REQ'(1) << hs_id[n-1]) || bus.rsp_sum !== exp_sum[hs_id[n-1]]) begin
               bad++;
               $display("FAIL rr_rsp op %0d: rsp_valid=%b rsp_sum=%h, required bit %0d sum %h",
                        n - 1, bus.rsp_valid, bus.rsp_sum, hs_id[n-1], exp_sum[hs_id[n-1]]);
            end
         end
         tick();
      end
      bus.req_valid = '0;
      wait_idle("rr_drain", 20);
      total++;
      if (n != 5) begin
         bad++;
         $display("FAIL rr_count: saw %0d grants, required 5", n);
      end else begin
         for (int k = 0; k < 5; k++) begin
            total++;
            if (hs_id[k] != exp_id[k]) begin
               bad++;
               $display("FAIL rr_order grant %0d: got requester %0d, required %0d", k, hs_id[k], exp_id[k]);
            end
            if (k > 0) begin
               total++;
               if (hs_cyc[k] - hs_cyc[k-1] != ADD_LAT + 2) begin
                  bad++;
                  $display("FAIL rr_spacing grant %0d: gap %0d cycles, required %0d",
                           k, hs_cyc[k] - hs_cyc[k-1], ADD_LAT + 2);
               end
            end
         end
      end
   endtask

   task automatic test_backpressure();
      set_ops(1, 32'h1234_0000, 32'h0000_5678);
      set_ops(3, 32'd100, 32'd23);
      bus.rsp_ready = '0;
      bus.req_valid = 4'b0010;
      #1;
      total++;
      if (bus.req_ready !== 4'b0010) begin
         bad++;
         $display("FAIL bp_req_ready: got %b, required 0010", bus.req_ready);
      end
      tick();
      bus.req_valid = 4'b1000;
      repeat (ADD_LAT) tick();
      for (int h = 0; h < 10; h++) begin
         total++;
         if (bus.rsp_valid !== 4'b0010 || bus.rsp_sum !== 32'h1234_5678 || bus.req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL bp_hold cycle %0d: rsp_valid=%b rsp_sum=%h req_ready=%b, required 0010 12345678 0000",
                     h, bus.rsp_valid, bus.rsp_sum, bus.req_ready);
         end
         if (h == 4) bus.rsp_ready = 4'b0001;
         tick();
      end
      bus.rsp_ready = 4'b0011;
      #1;
      total++;
      if (bus.rsp_valid !== 4'b0010) begin
         bad++;
         $display("FAIL bp_before_accept: rsp_valid=%b, required 0010", bus.rsp_valid);
      end
      tick();
      total++;
      if (bus.req_ready !== 4'b1000 || bus.busy !== 1'b0 || bus.rsp_valid !== 4'b0000) begin
         bad++;
         $display("FAIL bp_next_grant: req_ready=%b busy=%b rsp_valid=%b, required 1000 0 0000",
                  bus.req_ready, bus.busy, bus.rsp_valid);
      end
      tick();
      bus.req_valid = '0;
      bus.rsp_ready = '1;
      total++;
      if (bus.grant_id !== 2'd3 || bus.add_a !== 32'd100 || bus.add_b !== 32'd23) begin
         bad++;
         $display("FAIL bp_req3_ops: grant_id=%0d add_a=%h add_b=%h, required 3 64 17",
                  bus.grant_id, bus.add_a, bus.add_b);
      end
      repeat (ADD_LAT) tick();
      total++;
      if (bus.rsp_valid !== 4'b1000 || bus.rsp_sum !== 32'd123) begin
         bad++;
         $display("FAIL bp_req3_rsp: rsp_valid=%b rsp_sum=%h, required 1000 0000007b", bus.rsp_valid, bus.rsp_sum);
      end
      wait_idle("bp_drain", 10);
   endtask

   task automatic test_reset_mid();
      int left;
      do_op("pre_reset", 1, 32'd10, 32'd20, 32'd30);
      set_ops(1, 32'h0000_AAAA, 32'h0000_5555);
      bus.req_valid = 4'b0010;
      #1;
      tick();
      bus.req_valid = '0;
      tick();
      rst_n = 1'b0;
      #1;
      total++;
      if ({bus.busy, bus.rsp_valid, bus.grant_id, bus.req_ready} !== 11'b0) begin
         bad++;
         $display("FAIL mid_reset_ctrl: busy=%b rsp_valid=%b grant_id=%0d req_ready=%b, required all 0",
                  bus.busy, bus.rsp_valid, bus.grant_id, bus.req_ready);
      end
      total++;
      if ({bus.add_a, bus.add_b, bus.rsp_sum} !== 96'b0) begin
         bad++;
         $display("FAIL mid_reset_data: add_a=%h add_b=%h rsp_sum=%h, required 0",
                  bus.add_a, bus.add_b, bus.rsp_sum);
      end
      set_ops(0, 32'd1, 32'd2);
      set_ops(3, 32'd3, 32'd4);
      bus.req_valid = 4'b1001;
      bus.rsp_ready = '1;
      #1;
      total++;
      if (bus.req_ready !== 4'b0000) begin
         bad++;
         $display("FAIL mid_reset_req_ready: got %b while in reset, required 0000", bus.req_ready);
      end
      tick();
      rst_n = 1'b1;
      #1;
      total++;
      if (bus.req_ready !== 4'b0001) begin
         bad++;
         $display("FAIL post_reset_first: req_ready=%b, required 0001", bus.req_ready);
      end
      tick();
      bus.req_valid = 4'b1000;
      total++;
      if (bus.grant_id !== 2'd0 || bus.add_a !== 32'd1) begin
         bad++;
         $display("FAIL post_reset_grant0: grant_id=%0d add_a=%h, required 0 1", bus.grant_id, bus.add_a);
      end
      left = 20;
      while (bus.req_ready === 4'b0000 && left > 0) begin
         tick();
         left--;
      end
      total++;
      if (bus.req_ready !== 4'b1000) begin
         bad++;
         $display("FAIL post_reset_second: req_ready=%b, required 1000", bus.req_ready);
      end
      tick();
      bus.req_valid = '0;
      total++;
      if (bus.grant_id !== 2'd3) begin
         bad++;
         $display("FAIL post_reset_grant3: grant_id=%0d, required 3", bus.grant_id);
      end
      wait_idle("post_reset_drain", 10);
   endtask

   initial begin
      bus.req_valid = '0;
      bus.rsp_ready = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      test_reset();
      test_single();
      test_wrap();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/add_arbiter.md
# add_arbiter

Shares one 32-bit carry-lookahead adder instance between `N_REQ` requesters. It uses round-robin arbitration with a valid/ready handshake on both the request side and the response side. The block sits between the ALU-side clients and the shared `Add` datapath: it drives the adder operands from registers, waits a fixed `ADD_LAT` cycles for the sum to settle, then returns the result to the granted requester. One operation is in flight at a time.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 32: operand and sum width.
- `ADD_LAT`, 3: cycles, ≥1, from the operand registers updating to the adder sum being sampled.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: per-requester request valid.
- `req_ready` out N_REQ: per-requester accept; at most one bit set.
- `req_a` in N_REQ*WIDTH: operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b` in N_REQ*WIDTH: operand B, same packing as `req_a`.
- `rsp_valid` out N_REQ: one-hot response valid to the owner.
- `rsp_sum` out WIDTH: shared response data bus.
- `rsp_ready` in N_REQ: per-requester response accept.
- `add_a`, `add_b` out WIDTH: registered operands to the adder.
- `add_sum` in WIDTH: adder result; no carry-out.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `grant_id` out $clog2(N_REQ): index of the current or most recent owner.

## Operation
- FSM states and transitions:
  - IDLE → EXEC on any request handshake.
  - EXEC → RESP when the latency counter expires.
  - RESP → IDLE on the response handshake.
- IDLE:
  - `req_ready` is combinational and one-hot: the first `req_valid` bit found searching upward from `ptr`, wrapping modulo N_REQ.
  - Handshake = `req_valid[i] & req_ready[i]`.
  - On handshake: latch `req_a[i]`/`req_b[i]` into `add_a`/`add_b`, set `grant_id`=i, load `cnt`=ADD_LAT, go to EXEC.
- EXEC:
  - `req_ready`=0; `cnt` decrements each cycle.
  - In the cycle `cnt`==1, register `add_sum` into `rsp_sum` and go to RESP.
- RESP:
  - `rsp_valid[grant_id]`=1; `rsp_sum` is held stable.
  - On `rsp_ready[grant_id]`: clear `rsp_valid`, set `ptr`=(grant_id+1) mod N_REQ, go to IDLE.
  - `rsp_ready` bits of non-owners are ignored.
- Arithmetic is modulo 2^WIDTH; the carry-out is discarded.
- `add_a`, `add_b`, `rsp_sum` and `grant_id` keep their last values after the response.
- Requesters may drop `req_valid` before grant without penalty. Operands are sampled only on the handshake cycle.

## Timing
- Reset values:
  - `req_ready`=0 while `rst_n` is low.
  - `rsp_valid`=0, `rsp_sum`=0, `add_a`=0, `add_b`=0, `busy`=0, `grant_id`=0.
  - `ptr`=0, state=IDLE.
- Request handshake at edge 0. `add_a`/`add_b` are valid from cycle 1. `add_sum` is sampled at edge ADD_LAT. `rsp_valid` is high from cycle ADD_LAT+1.
- With `rsp_ready` already high: response handshake at edge ADD_LAT+1, IDLE in cycle ADD_LAT+2. The next request can be accepted at that edge.
- Minimum period is ADD_LAT+2 cycles per operation.
- Simultaneous requests: exactly one is granted per IDLE cycle. The others keep `req_valid` high and wait.
- Reset asserted mid-operation aborts immediately:
  - All outputs take reset values; the pending response is lost.
  - `ptr` returns to 0.

## Configuration
- `ADD_ARB_FIXED_PRIO_EN`:
  - Defined: the IDLE winner is the lowest-index valid requester. `ptr` is unused and held at 0.
  - Undefined (default): round-robin as described above.
- All other behaviour is identical in both builds.

## Test plan
- Single op: requester 2 sends a=0x0000_0005, b=0x0000_0007 with ADD_LAT=3 and a behavioural adder model.
  - `req_ready[2]` is high in the same cycle.
  - `rsp_valid[2]` rises 4 cycles after the handshake with `rsp_sum`=0x0000_000C.
  - `busy` is high for exactly 4 cycles.
- Wrap-around: a=0xFFFF_FFFF, b=0x0000_0001 → `rsp_sum`=0x0000_0000. Also a=0x8000_0000, b=0x8000_0000 → 0x0000_0000.
- Round-robin: all 4 requesters hold `req_valid` continuously with `rsp_ready` tied high.
  - Grant order is 0,1,2,3,0.
  - Handshakes are spaced 5 cycles apart.
  - With `ADD_ARB_FIXED_PRIO_EN`: requester 0 is granted every time.
- Response backpressure: `rsp_ready[1]` is held low for 10 cycles.
  - `rsp_valid[1]` and `rsp_sum` stay stable and `req_ready` stays 0.
  - The request from requester 3 is granted the cycle after `rsp_ready[1]` rises.
  - A non-owner raising `rsp_ready[0]` has no effect.
- Reset mid-EXEC: pull `rst_n` low at cycle 2 after a handshake.
  - All outputs become 0 asynchronously.
  - After release, requesters 0 and 3 request together → 0 is granted first (`ptr` reset).
